// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo
// Serial receive front end. The asynchronous rx pin is synchronised into the
// clk25 domain, 8N1 frames are deserialised LSB-first, and good bytes are
// queued in a first-word-fall-through FIFO that the CPU side drains one byte
// per rd strobe. Framing errors and overruns are sticky until clr_err.
//
// Ports
//   clk25     in   system clock (only clock)
//   rst       in   synchronous active-high reset
//   rx        in   raw UART line, asynchronous, idles high
//   rd        in   pop strobe
//   clr_err   in   clears overrun and frame_err
//   data      out  FIFO head byte, meaningful only while ready = 1
//   ready     out  FIFO not empty
//   count     out  FIFO occupancy, DEPTH_LOG2+1 bits
//   overrun   out  sticky: good byte arrived while FIFO full
//   frame_err out  sticky: stop bit sampled low
//
// Read handshake: ready is the valid of the head byte; a byte is consumed on
// every clock edge where rd and ready are both 1. rd with ready = 0 is ignored.
module uart_rx_fifo #(
    parameter int unsigned CLK_HZ     = 25175000,
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned DEPTH_LOG2 = 4
) (
    input  logic                  clk25,
    input  logic                  rst,
    input  logic                  rx,
    input  logic                  rd,
    input  logic                  clr_err,
    output logic [7:0]            data,
    output logic                  ready,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  overrun,
    output logic                  frame_err
);

    localparam int unsigned DIV   = (CLK_HZ + BAUD / 2) / BAUD;
    localparam int unsigned TW    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned CW    = DEPTH_LOG2 + 1;

    localparam logic [TW-1:0] TICK_BIT  = TW'(DIV - 1);
    localparam logic [TW-1:0] TICK_HALF = TW'(DIV / 2 - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_e;

    // ------------------------------------------------------------------
    // Synchroniser. All stages reset high so the line looks idle and no
    // falling edge can be manufactured by reset itself.
    // ------------------------------------------------------------------
    logic sync1_q;
    logic rxs_q;
    logic rxp_q;

    always_ff @(posedge clk25) begin
        if (rst) begin
            sync1_q <= 1'b1;
            rxs_q   <= 1'b1;
            rxp_q   <= 1'b1;
        end else begin
            sync1_q <= rx;
            rxs_q   <= sync1_q;
            rxp_q   <= rxs_q;
        end
    end

    // ------------------------------------------------------------------
    // Receive FSM
    // ------------------------------------------------------------------
    state_e         state_q, state_d;
    logic [TW-1:0]  tick_q, tick_d;
    logic [2:0]     bitn_q, bitn_d;
    logic [7:0]     shift_q, shift_d;
    logic           push;
    logic           frame_set;

    always_ff @(posedge clk25) begin
        if (rst) begin
            state_q <= IDLE;
            tick_q  <= '0;
            bitn_q  <= '0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            bitn_q  <= bitn_d;
            shift_q <= shift_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        tick_d    = tick_q;
        bitn_d    = bitn_q;
        shift_d   = shift_q;
        push      = 1'b0;
        frame_set = 1'b0;

        case (state_q)
            IDLE: begin
                // Only a 1->0 transition starts a frame, so a held-low
                // break cannot retrigger reception.
                if (rxp_q && !rxs_q) begin
                    state_d = START;
                    tick_d  = TICK_HALF;
                    bitn_d  = '0;
                end
            end
            START: begin
                if (tick_q == '0) begin
                    bitn_d = '0;
                    if (rxs_q) begin
                        state_d = IDLE;
                        tick_d  = '0;
                    end else begin
                        state_d = DATA;
                        tick_d  = TICK_BIT;
                    end
                end else begin
                    tick_d = tick_q - TW'(1);
                end
            end
            DATA: begin
                if (tick_q == '0) begin
                    shift_d = {rxs_q, shift_q[7:1]};
                    tick_d  = TICK_BIT;
                    if (bitn_q == 3'd7) begin
                        state_d = STOP;
                        bitn_d  = '0;
                    end else begin
                        bitn_d = bitn_q + 3'd1;
                    end
                end else begin
                    tick_d = tick_q - TW'(1);
                end
            end
            STOP: begin
                if (tick_q == '0) begin
                    if (rxs_q) begin
                        push = 1'b1;
                    end else begin
                        frame_set = 1'b1;
                    end
                    state_d = IDLE;
                    tick_d  = '0;
                    bitn_d  = '0;
                end else begin
                    tick_d = tick_q - TW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                tick_d  = '0;
                bitn_d  = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FIFO
    // ------------------------------------------------------------------
    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wp_q, rp_q;
    logic [CW-1:0]         count_q;
    logic                  overrun_q, frame_err_q;
    logic                  pop, full, wr_en, overrun_set;

    assign pop  = rd && (count_q != '0);
    assign full = (count_q == CW'(DEPTH));
    // A simultaneous pop frees the head slot, so a push into a full FIFO
    // still lands when it coincides with a read.
    assign wr_en       = push && (!full || pop);
    assign overrun_set = push && full && !pop;

    always_ff @(posedge clk25) begin
        if (!rst && wr_en) begin
            mem[wp_q] <= shift_q;
        end
    end

    always_ff @(posedge clk25) begin
        if (rst) begin
            wp_q    <= '0;
            rp_q    <= '0;
            count_q <= '0;
        end else begin
            if (wr_en) begin
                wp_q <= wp_q + DEPTH_LOG2'(1);
            end
            if (pop) begin
                rp_q <= rp_q + DEPTH_LOG2'(1);
            end
            case ({wr_en, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Sticky flags: a set event in the same cycle as clr_err wins.
    always_ff @(posedge clk25) begin
        if (rst) begin
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            overrun_q   <= overrun_set | (overrun_q & ~clr_err);
            frame_err_q <= frame_set | (frame_err_q & ~clr_err);
        end
    end

    assign data      = mem[rp_q];
    assign ready     = (count_q != '0);
    assign count     = count_q;
    assign overrun   = overrun_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo with DIV = 10 and a 4-entry FIFO.
// Inputs change on the falling clock edge; outputs are checked there too.
module tb_uart_rx_fifo;

    localparam int CLK_HZ     = 1000000;
    localparam int BAUD       = 100000;
    localparam int DEPTH_LOG2 = 2;
    localparam int DIV        = 10;

    logic       clk25   = 1'b0;
    logic       rst     = 1'b1;
    logic       rx      = 1'b1;
    logic       rd      = 1'b0;
    logic       clr_err = 1'b0;
    logic [7:0] data;
    logic       ready;
    logic [2:0] count;
    logic       overrun;
    logic       frame_err;

    int checks   = 0;
    int failures = 0;
    logic [7:0] exp_q[$];

    uart_rx_fifo #(
        .CLK_HZ    (CLK_HZ),
        .BAUD      (BAUD),
        .DEPTH_LOG2(DEPTH_LOG2)
    ) dut (
        .clk25    (clk25),
        .rst      (rst),
        .rx       (rx),
        .rd       (rd),
        .clr_err  (clr_err),
        .data     (data),
        .ready    (ready),
        .count    (count),
        .overrun  (overrun),
        .frame_err(frame_err)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk25 = ~clk25;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    // ---------------- driver tasks (call on a falling edge) ----------------
    task automatic send_frame(input logic [7:0] b, input logic stop);
        rx = 1'b0;
        repeat (DIV) @(negedge clk25);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (DIV) @(negedge clk25);
        end
        rx = stop;
        repeat (DIV) @(negedge clk25);
        rx = 1'b1;
    endtask

    task automatic pulse_rd();
        rd = 1'b1;
        @(negedge clk25);
        rd = 1'b0;
    endtask

    task automatic pulse_clr();
        clr_err = 1'b1;
        @(negedge clk25);
        clr_err = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk25);
        rst = 1'b0;
        checks++; if (ready !== 1'b0) begin failures++; $display("FAIL reset_ready: got %b expected 0", ready); end
        checks++; if (count !== 3'd0) begin failures++; $display("FAIL reset_count: got %0d expected 0", count); end
        checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
        checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL reset_frame_err: got %b expected 0", frame_err); end
        checks++; if (dut.state_q !== 2'd0) begin failures++; $display("FAIL reset_state: got %0d expected 0", dut.state_q); end
        repeat (2) @(negedge clk25);
    endtask

    task automatic test_single_byte();
        int cyc;
        bit seen;
        cyc  = 0;
        seen = 0;
        fork
            send_frame(8'hA5, 1'b1);
            begin
                while (!seen && cyc < 200) begin
                    @(negedge clk25);
                    cyc++;
                    if (ready) seen = 1;
                end
            end
        join
        checks++; if (!seen || cyc < 97 || cyc > 99) begin failures++; $display("FAIL single_latency: got %0d cycles (seen=%0d) expected 97..99", cyc, seen); end
        checks++; if (data !== 8'hA5) begin failures++; $display("FAIL single_data: got %h expected a5", data); end
        checks++; if (count !== 3'd1) begin failures++; $display("FAIL single_count: got %0d expected 1", count); end
        pulse_rd();
        checks++; if (ready !== 1'b0) begin failures++; $display("FAIL single_pop_ready: got %b expected 0", ready); end
        checks++; if (count !== 3'd0) begin failures++; $display("FAIL single_pop_count: got %0d expected 0", count); end
        // read while empty must not disturb anything
        pulse_rd();
        checks++; if (count !== 3'd0) begin failures++; $display("FAIL empty_rd_count: got %0d expected 0", count); end
        checks++; if (ready !== 1'b0) begin failures++; $display("FAIL empty_rd_ready: got %b expected 0", ready); end
    endtask

    task automatic test_burst_wrap();
        logic [7:0] exp_b;
        exp_q.delete();
        for (int v = 1; v <= 6; v++) begin
            send_frame(8'(v), 1'b1);
            if (exp_q.size() < 4) exp_q.push_back(8'(v));
        end
        repeat (3) @(negedge clk25);
        checks++; if (count !== 3'd4) begin failures++; $display("FAIL burst_count: got %0d expected 4", count); end
        checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL burst_overrun: got %b expected 1", overrun); end
        for (int i = 0; i < 2; i++) begin
            exp_b = exp_q.pop_front();
            checks++; if (data !== exp_b) begin failures++; $display("FAIL burst_head%0d: got %h expected %h", i, data, exp_b); end
            pulse_rd();
        end
        send_frame(8'h07, 1'b1);
        exp_q.push_back(8'h07);
        send_frame(8'h08, 1'b1);
        exp_q.push_back(8'h08);
        repeat (3) @(negedge clk25);
        checks++; if (count !== 3'd4) begin failures++; $display("FAIL wrap_count: got %0d expected 4", count); end
        for (int i = 0; i < 4; i++) begin
            exp_b = exp_q.pop_front();
            checks++; if (data !== exp_b) begin failures++; $display("FAIL wrap_head%0d: got %h expected %h", i, data, exp_b); end
            pulse_rd();
        end
        checks++; if (count !== 3'd0) begin failures++; $display("FAIL wrap_drained: got %0d expected 0", count); end
        pulse_clr();
        checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL overrun_clear: got %b expected 0", overrun); end
    endtask

    task automatic test_frame_break();
        send_frame(8'h11, 1'b1);
        send_frame(8'h3C, 1'b0);
        repeat (2) @(negedge clk25);
        checks++; if (frame_err !== 1'b1) begin failures++; $display("FAIL frame_err_set: got %b expected 1", frame_err); end
        checks++; if (count !== 3'd1) begin failures++; $display("FAIL frame_count: got %0d expected 1", count); end
        pulse_clr();
        checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL frame_err_clear: got %b expected 0", frame_err); end
        // break: line held low for 30 bit-times in total
        rx = 1'b0;
        repeat (12 * DIV) @(negedge clk25);
        checks++; if (frame_err !== 1'b1) begin failures++; $display("FAIL break_frame_err: got %b expected 1", frame_err); end
        checks++; if (count !== 3'd1) begin failures++; $display("FAIL break_count: got %0d expected 1", count); end
        pulse_clr();
        repeat (18 * DIV - 1) @(negedge clk25);
        checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL break_single_err: got %b expected 0", frame_err); end
        checks++; if (dut.state_q !== 2'd0) begin failures++; $display("FAIL break_idle: got %0d expected 0", dut.state_q); end
        rx = 1'b1;
        repeat (2 * DIV) @(negedge clk25);
        checks++; if (count !== 3'd1) begin failures++; $display("FAIL break_no_push: got %0d expected 1", count); end
        checks++; if (data !== 8'h11) begin failures++; $display("FAIL break_head: got %h expected 11", data); end
        pulse_rd();
    endtask

    task automatic test_glitch();
        rx = 1'b0;
        repeat (3) @(negedge clk25);
        rx = 1'b1;
        @(negedge clk25);
        checks++; if (dut.state_q !== 2'd1) begin failures++; $display("FAIL glitch_start: got %0d expected 1", dut.state_q); end
        repeat (20) @(negedge clk25);
        checks++; if (dut.state_q !== 2'd0) begin failures++; $display("FAIL glitch_idle: got %0d expected 0", dut.state_q); end
        checks++; if (count !== 3'd0) begin failures++; $display("FAIL glitch_count: got %0d expected 0", count); end
        checks++; if ({overrun, frame_err} !== 2'b00) begin failures++; $display("FAIL glitch_flags: got %b expected 00", {overrun, frame_err}); end
    endtask

    task automatic test_simultaneous();
        logic [7:0] exp_b;
        exp_q.delete();
        for (int v = 8'h21; v <= 8'h24; v++) begin
            send_frame(8'(v), 1'b1);
            exp_q.push_back(8'(v));
        end
        repeat (2) @(negedge clk25);
        checks++; if (count !== 3'd4) begin failures++; $display("FAIL simul_full: got %0d expected 4", count); end
        // stop bit of the next frame is sampled on the 98th rising edge
        fork
            send_frame(8'h25, 1'b1);
            begin
                repeat (97) @(negedge clk25);
                rd = 1'b1;
                @(negedge clk25);
                rd = 1'b0;
            end
        join
        void'(exp_q.pop_front());
        exp_q.push_back(8'h25);
        repeat (2) @(negedge clk25);
        checks++; if (count !== 3'd4) begin failures++; $display("FAIL simul_count: got %0d expected 4", count); end
        checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL simul_overrun: got %b expected 0", overrun); end
        for (int i = 0; i < 4; i++) begin
            exp_b = exp_q.pop_front();
            checks++; if (data !== exp_b) begin failures++; $display("FAIL simul_head%0d: got %h expected %h", i, data, exp_b); end
            pulse_rd();
        end
        fork
            send_frame(8'h55, 1'b0);
            begin
                repeat (97) @(negedge clk25);
                clr_err = 1'b1;
                @(negedge clk25);
                clr_err = 1'b0;
            end
        join
        checks++; if (frame_err !== 1'b1) begin failures++; $display("FAIL set_beats_clear: got %b expected 1", frame_err); end
        pulse_clr();
        checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL simul_clear: got %b expected 0", frame_err); end
    endtask

    task automatic test_reset_mid();
        send_frame(8'h31, 1'b1);
        send_frame(8'h32, 1'b1);
        send_frame(8'h44, 1'b0);
        repeat (2) @(negedge clk25);
        checks++; if (count !== 3'd2) begin failures++; $display("FAIL pre_reset_count: got %0d expected 2", count); end
        // 0xF0: data bits 4..7 and stop are high, so the tail of the
        // aborted frame cannot form a new falling edge
        fork
            send_frame(8'hF0, 1'b1);
            begin
                repeat (55) @(negedge clk25);
                rst = 1'b1;
                @(negedge clk25);
                rst = 1'b0;
                checks++; if (ready !== 1'b0) begin failures++; $display("FAIL mid_reset_ready: got %b expected 0", ready); end
                checks++; if (count !== 3'd0) begin failures++; $display("FAIL mid_reset_count: got %0d expected 0", count); end
                checks++; if ({overrun, frame_err} !== 2'b00) begin failures++; $display("FAIL mid_reset_flags: got %b expected 00", {overrun, frame_err}); end
                checks++; if (dut.state_q !== 2'd0) begin failures++; $display("FAIL mid_reset_state: got %0d expected 0", dut.state_q); end
            end
        join
        repeat (5) @(negedge clk25);
        checks++; if (count !== 3'd0) begin failures++; $display("FAIL aborted_frame: got %0d expected 0", count); end
        send_frame(8'h5A, 1'b1);
        repeat (2) @(negedge clk25);
        checks++; if (count !== 3'd1) begin failures++; $display("FAIL post_reset_count: got %0d expected 1", count); end
        checks++; if (data !== 8'h5A) begin failures++; $display("FAIL post_reset_data: got %h expected 5a", data); end
        pulse_rd();
        checks++; if (ready !== 1'b0) begin failures++; $display("FAIL post_reset_drain: got %b expected 0", ready); end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        @(negedge clk25);
        test_reset();
        test_single_byte();
        test_burst_wrap();
        test_frame_break();
        test_glitch();
        test_simultaneous();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
